// File: rtl/cnn_pkg.sv
// Shared CNN pipeline constants: tensor sizes, channel data width and an index-width helper.
// The ReLU, pool-window and pool stages all take these values from here.
package cnn_pkg;

  localparam int unsigned DW     = 69;  // signed bits per channel
  localparam int unsigned CH     = 8;   // channels per pixel beat
  localparam int unsigned RELU_X = 24;
  localparam int unsigned RELU_Y = 24;
  localparam int unsigned POOL_X = 12;
  localparam int unsigned POOL_Y = 12;
  localparam int unsigned STRIDE = 2;

  // Bits needed to index 0..n-1; never less than 1 so a degenerate size still gets a port.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Single-row line buffer for the 2x2 pool window generator.
// One synchronous write port and one combinational read port; contents are never reset.
//   clk      clock
//   we_i     write enable
//   waddr_i  write column
//   wdata_i  pixel bundle to store
//   raddr_i  read column
//   rdata_o  stored pixel bundle at raddr_i (combinational)
module pool_line_buf #(
  parameter int unsigned Depth = 24,
  parameter int unsigned Width = 552,
  parameter int unsigned AddrW = 5
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pool_window_gen.sv
// Builds non-overlapping 2x2 (stride 2) windows from a raster pixel stream for pool_layer.
// Even rows are stored in a line buffer; on odd rows the even-column pixel and its upper
// neighbour are held, and the odd-column beat completes the window, registered one cycle later.
//   clk, rst          clock, synchronous active-high reset
//   in_valid, in_sof  beat strobe, start-of-frame (forces the beat to row 0, col 0)
//   in_data           CH channels, channel c at [c*DW +: DW]
//   win_valid         one-cycle window strobe
//   win_00..win_11    top-left, top-right, bottom-left, bottom-right pixels
//   win_row, win_col  pooled window coordinates
//   frame_done        pulses with the last window of a frame
module pool_window_gen
  import cnn_pkg::*;
#(
  parameter int unsigned IN_X = RELU_X,
  parameter int unsigned IN_Y = RELU_Y,
  parameter int unsigned CH_N = CH,
  parameter int unsigned D_W  = DW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_sof,
  input  logic [CH_N*D_W-1:0]         in_data,
  output logic                        win_valid,
  output logic [CH_N*D_W-1:0]         win_00,
  output logic [CH_N*D_W-1:0]         win_01,
  output logic [CH_N*D_W-1:0]         win_10,
  output logic [CH_N*D_W-1:0]         win_11,
  output logic [idx_w(IN_Y/2)-1:0]    win_row,
  output logic [idx_w(IN_X/2)-1:0]    win_col,
  output logic                        frame_done
);

  localparam int unsigned ColW    = idx_w(IN_X);
  localparam int unsigned RowW    = idx_w(IN_Y);
  localparam int unsigned WinColW = idx_w(IN_X/2);
  localparam int unsigned WinRowW = idx_w(IN_Y/2);
  localparam int unsigned BusW    = CH_N * D_W;
  localparam logic [ColW-1:0] LastCol = ColW'(IN_X - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(IN_Y - 1);

  logic [ColW-1:0]    col_q, col_d, eff_col;
  logic [RowW-1:0]    row_q, row_d, eff_row;
  logic [BusW-1:0]    left_q, top_q, lb_rdata;
  logic               lb_we, hold_en, win_fire, last_pos;
  logic               win_valid_q, frame_done_q;
  logic [BusW-1:0]    win_00_q, win_01_q, win_10_q, win_11_q;
  logic [WinRowW-1:0] win_row_q;
  logic [WinColW-1:0] win_col_q;

  always_comb begin
    // in_sof relabels the beat as (0,0), which also drops any half-built window.
    eff_col  = in_sof ? '0 : col_q;
    eff_row  = in_sof ? '0 : row_q;
    col_d    = col_q;
    row_d    = row_q;
    if (in_valid) begin
      if (eff_col == LastCol) begin
        col_d = '0;
        row_d = (eff_row == LastRow) ? '0 : eff_row + 1'b1;
      end else begin
        col_d = eff_col + 1'b1;
        row_d = eff_row;
      end
    end
    lb_we    = in_valid & ~eff_row[0];
    hold_en  = in_valid &  eff_row[0] & ~eff_col[0];
    win_fire = in_valid &  eff_row[0] &  eff_col[0];
    last_pos = (eff_row == LastRow) && (eff_col == LastCol);
  end

  // Read address is the current column: on the even column it fetches the future top-left
  // (captured in top_q), on the odd column the top-right, so one read port suffices.
  pool_line_buf #(
    .Depth (IN_X),
    .Width (BusW),
    .AddrW (ColW)
  ) u_line_buf (
    .clk     (clk),
    .we_i    (lb_we),
    .waddr_i (eff_col),
    .wdata_i (in_data),
    .raddr_i (eff_col),
    .rdata_o (lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (hold_en) begin
      left_q <= in_data;
      top_q  <= lb_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_00_q     <= '0;
      win_01_q     <= '0;
      win_10_q     <= '0;
      win_11_q     <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_fire;
      frame_done_q <= win_fire & last_pos;
      if (win_fire) begin
        win_00_q  <= top_q;
        win_01_q  <= lb_rdata;
        win_10_q  <= left_q;
        win_11_q  <= in_data;
        win_row_q <= WinRowW'(eff_row >> 1);
        win_col_q <= WinColW'(eff_col >> 1);
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win_00     = win_00_q;
  assign win_01     = win_01_q;
  assign win_10     = win_10_q;
  assign win_11     = win_11_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Scoreboard bench for pool_window_gen: the driver pushes the expected window whenever it
// issues a completing beat; a negedge monitor pops and compares every presented window.
module tb_pool_window_gen;

  localparam int IN_X = 24;
  localparam int IN_Y = 24;
  localparam int CH   = 8;
  localparam int DW   = 69;
  localparam int BW   = CH * DW;
  localparam int WRW  = $clog2(IN_Y/2);
  localparam int WCW  = $clog2(IN_X/2);

  typedef struct {
    logic [BW-1:0] w00, w01, w10, w11;
    int            r, k;
    bit            fd;
    int            due;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_sof = 1'b0;
  logic [BW-1:0]  in_data = '0;
  logic           win_valid, frame_done;
  logic [BW-1:0]  win_00, win_01, win_10, win_11;
  logic [WRW-1:0] win_row;
  logic [WCW-1:0] win_col;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_win = 0;
  int   n_fd = 0;
  exp_t sb[$];
  logic [BW-1:0] cap_first00, cap_first01, cap_first10, cap_first11, cap_last11;

  pool_window_gen #(
    .IN_X (IN_X),
    .IN_Y (IN_Y),
    .CH_N (CH),
    .D_W  (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .win_valid  (win_valid),
    .win_00     (win_00),
    .win_01     (win_01),
    .win_10     (win_10),
    .win_11     (win_11),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // mode 0: every channel row*100+col; mode 1: channel c = -(c+1)*row*100+col.
  function automatic logic [BW-1:0] pix(input int mode, input int r, input int c);
    logic [BW-1:0] v;
    longint        x;
    for (int ch = 0; ch < CH; ch++) begin
      if (mode == 0) x = longint'(r * 100 + c);
      else           x = -longint'(ch + 1) * longint'(r) * 100 + longint'(c);
      v[ch*DW +: DW] = {{(DW-64){x[63]}}, x};
    end
    return v;
  endfunction

  function automatic logic [BW-1:0] slice_val(input longint x);
    logic [BW-1:0] v;
    v = '0;
    v[DW-1:0] = {{(DW-64){x[63]}}, x};
    return v;
  endfunction

  // Drive one cycle; inputs change #1 after the active edge.
  task automatic drive(input bit v, input bit sof, input int mode, input int r, input int c);
    exp_t e;
    in_valid = v;
    in_sof   = sof;
    in_data  = v ? pix(mode, r, c) : pix(1, 77, 55);
    if (v && (r % 2 == 1) && (c % 2 == 1)) begin
      e.w00 = pix(mode, r - 1, c - 1);
      e.w01 = pix(mode, r - 1, c);
      e.w10 = pix(mode, r, c - 1);
      e.w11 = pix(mode, r, c);
      e.r   = r / 2;
      e.k   = c / 2;
      e.fd  = (r == IN_Y - 1) && (c == IN_X - 1);
      e.due = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0);
  endtask

  // Raster beats from (0,0); gap inserts an idle cycle (with a stray in_sof) after each beat.
  task automatic run_frame(input int mode, input bit gap, input bit sof_first, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      drive(1'b1, sof_first && (i == 0), mode, i / IN_X, i % IN_X);
      if (gap) drive(1'b0, 1'b1, mode, 0, 0);
    end
  endtask

  task automatic expect_counts(input string name, input int w0, input int f0,
                               input int dw, input int df);
    chk({name, "_windows"}, BW'(n_win - w0), BW'(dw));
    chk({name, "_frame_done"}, BW'(n_fd - f0), BW'(df));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (frame_done && !win_valid) begin
      checks++;
      errors++;
      $display("FAIL frame_done_alone: got frame_done=1 win_valid=0, required win_valid=1");
    end
    if (win_valid) begin
      n_win++;
      if (frame_done) begin
        n_fd++;
        cap_last11 = win_11;
      end
      if (win_row == 0 && win_col == 0) begin
        cap_first00 = win_00;
        cap_first01 = win_01;
        cap_first10 = win_10;
        cap_first11 = win_11;
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got win_valid=1 at (%0d,%0d), required none",
                 win_row, win_col);
      end else begin
        e = sb.pop_front();
        chk("latency", BW'(cyc), BW'(e.due));
        chk("win_00", win_00, e.w00);
        chk("win_01", win_01, e.w01);
        chk("win_10", win_10, e.w10);
        chk("win_11", win_11, e.w11);
        chk("win_row", BW'(win_row), BW'(e.r));
        chk("win_col", BW'(win_col), BW'(e.k));
        chk("frame_done", BW'(frame_done), BW'(e.fd));
      end
    end
  end

  initial begin
    int w0, f0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_win_valid", BW'(win_valid), '0);
    chk("rst_frame_done", BW'(frame_done), '0);
    chk("rst_win_11", win_11, '0);
    chk("rst_win_row", BW'(win_row), '0);

    // Full frame, continuous.
    w0 = n_win; f0 = n_fd;
    run_frame(0, 1'b0, 1'b1, IN_X * IN_Y);
    idle(3);
    expect_counts("frame1", w0, f0, 144, 1);
    for (int ch = 0; ch < CH; ch++) begin
      chk("first_w00", BW'(cap_first00[ch*DW +: DW]), BW'(0));
      chk("first_w01", BW'(cap_first01[ch*DW +: DW]), BW'(1));
      chk("first_w10", BW'(cap_first10[ch*DW +: DW]), BW'(100));
      chk("first_w11", BW'(cap_first11[ch*DW +: DW]), BW'(101));
    end
    chk("last_w11_ch7", BW'(cap_last11[7*DW +: DW]), BW'(2323));

    // Same frame with in_valid toggling; stray in_sof on idle cycles must be ignored.
    w0 = n_win; f0 = n_fd;
    run_frame(0, 1'b1, 1'b1, IN_X * IN_Y);
    idle(3);
    expect_counts("gapped", w0, f0, 144, 1);

    // Distinct signed per-channel data.
    w0 = n_win; f0 = n_fd;
    run_frame(1, 1'b0, 1'b1, IN_X * IN_Y);
    idle(3);
    expect_counts("signed", w0, f0, 144, 1);
    // Channel 3 of beat (23,23): -4*2300+23 = -9177.
    chk("last_w11_ch3", BW'(cap_last11[3*DW +: DW]), slice_val(-64'sd9177));
    chk("last_w11_ch3_sign", BW'(cap_last11[3*DW + DW - 1]), BW'(1));

    // in_sof at row 5, col 7: the partial frame yields 27 windows, no frame_done.
    w0 = n_win; f0 = n_fd;
    run_frame(0, 1'b0, 1'b1, 5 * IN_X + 7);
    run_frame(0, 1'b0, 1'b1, IN_X * IN_Y);
    idle(3);
    expect_counts("sof_abort", w0, f0, 27 + 144, 1);

    // Reset mid-frame with the next beat due at (13,3).
    run_frame(0, 1'b0, 1'b1, 13 * IN_X + 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_win_valid", BW'(win_valid), '0);
    chk("midrst_frame_done", BW'(frame_done), '0);
    chk("midrst_win_00", win_00, '0);
    chk("midrst_win_01", win_01, '0);
    chk("midrst_win_10", win_10, '0);
    chk("midrst_win_11", win_11, '0);
    chk("midrst_win_row", BW'(win_row), '0);
    chk("midrst_win_col", BW'(win_col), '0);
    w0 = n_win; f0 = n_fd;
    run_frame(1, 1'b0, 1'b0, IN_X * IN_Y);
    idle(3);
    expect_counts("after_rst", w0, f0, 144, 1);

    // Two back-to-back frames, no in_sof: relies on counter wrap (23,23)->(0,0).
    w0 = n_win; f0 = n_fd;
    run_frame(0, 1'b0, 1'b0, IN_X * IN_Y);
    run_frame(1, 1'b0, 1'b0, IN_X * IN_Y);
    idle(3);
    expect_counts("b2b", w0, f0, 288, 2);

    chk("scoreboard_empty", BW'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
- Sits between the ReLU stage and pool_layer.
- Consumes a raster-order stream of ReLU-activated pixels: IN_X x IN_Y per frame, CH channels per beat, DW-bit signed per channel.
- Buffers one even row, then assembles non-overlapping 2x2 windows (stride 2) for all channels and presents them as one registered, single-cycle-valid bundle that drives pool_layer's pool_c_00/01/10/11 inputs directly.

Parameters:
- IN_X, 24, pixels per row; must be even.
- IN_Y, 24, rows per frame; must be even.
- CH, 8, channels per pixel beat.
- DW, 69, signed data width per channel.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  pixel beat present this cycle.
- in_sof  in  1  qualifies in_valid; beat is pixel (row 0, col 0) of a new frame.
- in_data  in  CH*DW  channel c at bits [c*DW +: DW].
- win_valid  out  1  window bundle valid, one-cycle pulse.
- win_00  out  CH*DW  top-left pixel (row 2r, col 2k), same channel packing.
- win_01  out  CH*DW  top-right pixel (row 2r, col 2k+1).
- win_10  out  CH*DW  bottom-left pixel (row 2r+1, col 2k).
- win_11  out  CH*DW  bottom-right pixel (row 2r+1, col 2k+1).
- win_row  out  $clog2(IN_Y/2)  pooled row index r of the current window.
- win_col  out  $clog2(IN_X/2)  pooled column index k of the current window.
- frame_done  out  1  pulses together with the last window of a frame.

Behaviour:
- No backpressure. A beat is accepted whenever in_valid=1. Gaps (in_valid=0) freeze all state.
- Counters col (0..IN_X-1) and row (0..IN_Y-1) give the position of the next accepted beat.
- On an accepted beat with col=IN_X-1, col wraps to 0 and row increments. With row=IN_Y-1 as well, row also wraps to 0.
- Even row: beat data is written to line_buf[col]. No output is produced.
- Odd row, even col: beat data is captured in the hold register left_q.
- Odd row, odd col: next cycle the outputs register the window and win_valid=1:
  - win_00 = line_buf[col-1], win_01 = line_buf[col], win_10 = left_q, win_11 = in_data.
  - win_row = row>>1, win_col = col>>1.
- Latency: exactly 1 cycle from the completing beat to win_valid.
- win_valid is high for exactly one cycle per window. Data outputs hold their last value when win_valid=0.
- frame_done=1 in the same cycle as the window with win_row=IN_Y/2-1 and win_col=IN_X/2-1.
- Throughput: IN_X*IN_Y/4 windows per frame (144 at defaults). At most one window per 2 accepted beats.
- in_sof with in_valid: the beat is treated as row 0, col 0 regardless of counter state.
  - Counters restart and any partial window is discarded.
  - If the counters were not already (0,0), no window or frame_done is emitted for the aborted frame.
- in_sof without in_valid is ignored.
- Reset:
  - win_valid, frame_done, win_row, win_col, win_00..win_11, row, col all go to 0.
  - left_q and line_buf are not reset; their contents are don't-care until rewritten.
  - A mid-frame reset discards the frame. The next beat is taken as (0,0) whether or not in_sof is set.
- Data is passed through unmodified, with no sign or width change. Max selection is pool_layer's job.

Decomposition:
- Shared package cnn_pkg holds:
  - the data width DW=69, CH=8, RELU_X/RELU_Y=24, POOL_X/POOL_Y=12, STRIDE=2;
  - a function for index widths.
- pool_layer and this block both take these values from the package.
- One sub-module: pool_line_buf. It is a single-write/single-read register or RAM array of depth IN_X and width CH*DW, with a combinational read at the odd-row read address.
- Counters, left_q, and the output registers stay in the top module.

Test Plan:
- Reset then one full frame; in_data for every channel = row*100+col, in_valid constant -> 144 win_valid pulses. The first window (r=0,k=0) has win_00=0, win_01=1, win_10=100, win_11=101 on every channel, 1 cycle after beat (1,1). frame_done on window (11,11) with win_11=2323.
- Same frame with in_valid toggling 1,0,1,0 -> identical window contents and order. No win_valid while inputs stall.
- Distinct per-channel data (channel c = -(c+1)*row*100+col, including negatives) -> each DW slice maps to the correct channel. Sign bits are preserved.
- in_sof asserted at row 5, col 7 of a frame -> no window for the partial block. The following frame starts at (0,0), and its first window values match the first scenario.
- rst asserted for 1 cycle at row 13, col 3 -> win_valid=0 and all outputs 0 the next cycle. A clean frame afterwards yields 144 windows and one frame_done.
- Two back-to-back frames without in_sof -> wrap-around at (23,23)->(0,0). 288 windows and 2 frame_done pulses.
